param_serial_subtractor: RTL

- Multi-cycle, bit-serial, parameterized subtractor computing A − B, one bit per clock, LSB first.
- Inverse arithmetic companion to param_full_adder. Shares the same operand/result width convention: WIDTH-bit operands, WIDTH+1-bit result.
- Uses a start/busy/done handshake so a controller can issue operations and collect results.
- Trades latency for area: one full-subtractor cell plus shift registers.

---
 rtl/param_serial_subtractor.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/param_serial_subtractor.sv
// Bit-serial A - B subtractor, one bit per clock LSB first, start/busy/done handshake.
// Optional SERIAL_SUB_SIGNED_OVF_EN adds a signed-overflow output (ovf).
module param_serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             borrow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               br_q, br_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     result_q, result_d;
  logic               borrow_q, borrow_d;
  logic               diff_bit;
  logic               br_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs
  assign diff_bit = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
  assign br_nxt   = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = A;
          b_sr_d  = B;
          acc_d   = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
`endif
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        acc_d  = {diff_bit, acc_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = br_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Publish the completed difference; done/busy show it the following cycle
        busy_d   = 1'b1;
        done_d   = 1'b1;
        result_d = {br_q, acc_q};
        borrow_d = br_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ovf_d    = (a_msb_q != b_msb_q) && (acc_q[WIDTH-1] != a_msb_q);
`endif
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule
